seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the hex seven-segment display path. It latches a multi-digit hex value through a Load/Ready handshake and applies it only at frame boundaries, so the display never tears. It sequences one shared segment bus across NUM_DIGITS digit enables, inserting a blanking gap between digits to prevent ghosting. It owns the shared hex-to-segment decode and sits between the value producer and the board display pins.

Parameters:
NUM_DIGITS, 4, number of scanned digits; Value width = 4*NUM_DIGITS.
DWELL, 1000, clock cycles each digit is driven (must be >= 1).
BLANK, 8, clock cycles of all-off gap before each digit (must be >= 1).

Ports:
Clk  in  1  system clock, rising edge.
Rst_n  in  1  asynchronous active-low reset.
Value  in  4*NUM_DIGITS  hex value; nibble i drives digit i, digit 0 = least significant.
Load  in  1  request to capture Value; honoured only while Ready=1.
Ready  out  1  high when the pending-value slot is empty.
DpMask  in  NUM_DIGITS  decimal point per digit; sampled live, not latched.
LzBlank  in  1  leading-zero blanking enable; sampled live.
Segments  out  8  {dp,g,f,e,d,c,b,a}, active high.
DigitEn  out  NUM_DIGITS  one-hot digit enable, active high; all zero during BLANK.
FrameDone  out  1  one-cycle pulse marking the end of each full scan frame.

Behaviour:
- Reset is asynchronous active-low. The clock is Clk only. During reset, and on the first edge after release: state=BLANK, digit index=0, counter=0, displayed register=0, pending register=0, Ready=1, Segments=0, DigitEn=0, FrameDone=0.
- All outputs are registered.
- State BLANK: Segments=0, DigitEn=0. Runs BLANK cycles, then goes to SHOW for the same digit index.
- State SHOW: DigitEn=1<<idx, Segments=decode(displayed nibble idx), with dp=DpMask[idx]. Runs DWELL cycles, then goes to BLANK with idx+1.
- After digit NUM_DIGITS-1, idx wraps to 0.
- Frame length is exactly NUM_DIGITS*(BLANK+DWELL) cycles.
- Decode table (hex to {g..a}):
  0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Leading-zero blanking, when LzBlank=1: digit i>0 shows segments 0 (dp still per DpMask) if nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked. The digit stays enabled and timing is unchanged.
- Handshake:
  - Load=1 with Ready=1: Value is captured into the pending register at that edge, and Ready=0 from the next cycle.
  - Load while Ready=0: ignored; the pending value is not overwritten.
- Frame boundary is the last cycle of SHOW for digit NUM_DIGITS-1. On that cycle FrameDone=1 (registered, so it is visible in that cycle).
  - At the edge ending that cycle, if the pending slot is full: pending moves to displayed, and Ready=1 from the next cycle.
- Simultaneous events: Load with Ready=1 on the boundary cycle captures into pending only. The new value is displayed at the next boundary, not the current one.
- Rst_n assertion mid-frame or mid-handshake immediately returns everything to reset values. The pending value is discarded.
- The counter is wide enough for max(DWELL,BLANK). There is no overflow path.

Test Plan:
- Reset, NUM_DIGITS=4, DWELL=4, BLANK=2: all outputs 0, Ready=1. Frame cycles 0-1 DigitEn=0000; cycles 2-5 DigitEn=0001, Segments=3F; FrameDone first pulses at cycle 23.
- Load=1, Value=0x002A, LzBlank=0, DpMask=0: Ready drops next cycle. After the next FrameDone, digit0=77, digit1=5B, digit2=3F, digit3=3F; Ready returns to 1.
- Same value with LzBlank=1: digits2 and 3 show Segments=00 with DigitEn still asserted. With Value=0x0000, digit0 shows 3F and the rest show 00.
- A second Load of 0x1234 while Ready=0 is ignored; the display keeps 0x002A. A Load of 0x1234 on the FrameDone cycle is displayed only after the following FrameDone.
- DpMask=0100: digit2 Segments bit7=1 and all other digits have bit7=0; a DpMask change mid-frame takes effect on the next SHOW cycle.
- Rst_n pulsed low mid-SHOW of digit 2 with a load pending: outputs clear asynchronously, Ready=1, displayed=0, and the scan restarts at BLANK for digit 0.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Producer/display-side bundle for seg_scan_ctrl: value handshake, live display controls and scan pins.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] Value;
  logic                    Load;
  logic                    Ready;
  logic [NUM_DIGITS-1:0]   DpMask;
  logic                    LzBlank;
  logic [7:0]              Segments;
  logic [NUM_DIGITS-1:0]   DigitEn;
  logic                    FrameDone;

  modport master (
    output Value, Load, DpMask, LzBlank,
    input  Ready, Segments, DigitEn, FrameDone
  );

  modport slave (
    input  Value, Load, DpMask, LzBlank,
    output Ready, Segments, DigitEn, FrameDone
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: BLANK/SHOW per digit, all outputs registered (one cycle after state decision).
// Load is accepted only while Ready=1; a pending value is swapped into the display at the frame-end edge.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 1000,
  parameter int BLANK      = 8
) (
  input logic          Clk,
  input logic          Rst_n,
  seg_scan_ctrl_if.slave bus
);
  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW   = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t          state, nstate;
  logic [CW-1:0]   cnt, ncnt;
  logic [IW-1:0]   idx, nidx;
  logic [VW-1:0]   displayed;
  logic [VW-1:0]   pending;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic [3:0]      nib;
  logic [7:0]      nseg;
  logic [NUM_DIGITS-1:0] nen;
  logic            nfd;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
    endcase
  endfunction

  // upper_zero[i]: nibbles i..NUM_DIGITS-1 of the displayed value are all zero
  always_comb begin
    upper_zero = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (j >= i && displayed[4*j +: 4] != 4'h0) upper_zero[i] = 1'b0;
      end
    end
  end

  always_comb begin
    nstate = state;
    ncnt   = cnt + CW'(1);
    nidx   = idx;
    if (state == ST_BLANK) begin
      if (cnt == BLANK_LAST) begin
        nstate = ST_SHOW;
        ncnt   = '0;
      end
    end else if (cnt == DWELL_LAST) begin
      nstate = ST_BLANK;
      ncnt   = '0;
      nidx   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

  // Outputs are precomputed from the next state so they are valid in the same cycle as that state
  always_comb begin
    nib  = displayed[{nidx, 2'b00} +: 4];
    nseg = 8'h00;
    nen  = '0;
    if (nstate == ST_SHOW) begin
      nen       = NUM_DIGITS'(1) << nidx;
      nseg[7]   = bus.DpMask[nidx];
      nseg[6:0] = (bus.LzBlank && nidx != '0 && upper_zero[nidx]) ? 7'h00 : hex7(nib);
    end
    nfd = (nstate == ST_SHOW) && (nidx == IDX_LAST) && (ncnt == DWELL_LAST);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= ST_BLANK;
      cnt           <= '0;
      idx           <= '0;
      displayed     <= '0;
      pending       <= '0;
      bus.Ready     <= 1'b1;
      bus.Segments  <= 8'h00;
      bus.DigitEn   <= '0;
      bus.FrameDone <= 1'b0;
    end else begin
      state         <= nstate;
      cnt           <= ncnt;
      idx           <= nidx;
      bus.Segments  <= nseg;
      bus.DigitEn   <= nen;
      bus.FrameDone <= nfd;
      // Ready and a frame-end swap are mutually exclusive, so a boundary load lands in pending only
      if (bus.FrameDone && !bus.Ready) begin
        displayed <= pending;
        bus.Ready <= 1'b1;
      end
      if (bus.Load && bus.Ready) begin
        pending   <= bus.Value;
        bus.Ready <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, DWELL=4, BLANK=2 (24-cycle frames).
module tb_seg_scan_ctrl;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL(4), .BLANK(2)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_digit(input string tag, input logic [3:0] en, input logic [7:0] seg);
    chk({tag, "_en"}, {28'h0, bus.DigitEn}, {28'h0, en});
    chk({tag, "_seg"}, {24'h0, bus.Segments}, {24'h0, seg});
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    @(negedge Clk);
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) next_cycle();
  endtask

  task automatic release_reset();
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    @(negedge Clk);
    cyc = 0;
  endtask

  initial begin
    bus.Value = '0; bus.Load = 1'b0; bus.DpMask = '0; bus.LzBlank = 1'b0;

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_seg", {24'h0, bus.Segments}, 32'h0);
    chk("rst_en", {28'h0, bus.DigitEn}, 32'h0);
    chk("rst_fd", {31'h0, bus.FrameDone}, 32'h0);
    chk("rst_ready", {31'h0, bus.Ready}, 32'h1);

    // Frame timing
    release_reset();
    chk_digit("c0_blank", 4'b0000, 8'h00);
    run_to(1);  chk_digit("c1_blank", 4'b0000, 8'h00);
    run_to(2);  chk_digit("c2_d0", 4'b0001, 8'h3F);
    run_to(5);  chk_digit("c5_d0", 4'b0001, 8'h3F);
    run_to(6);  chk_digit("c6_blank", 4'b0000, 8'h00);
    run_to(22); chk("c22_fd", {31'h0, bus.FrameDone}, 32'h0);
    run_to(23); chk("c23_fd", {31'h0, bus.FrameDone}, 32'h1);
    chk_digit("c23_d3", 4'b1000, 8'h3F);
    run_to(24); chk("c24_fd", {31'h0, bus.FrameDone}, 32'h0);

    // Load 0x002A, then an ignored load of 0x1234
    bus.Value = 16'h002A; bus.Load = 1'b1;
    run_to(25); bus.Load = 1'b0;
    chk("load_ready_drop", {31'h0, bus.Ready}, 32'h0);
    run_to(26); bus.Value = 16'h1234; bus.Load = 1'b1;
    run_to(27); bus.Load = 1'b0;
    run_to(32); chk_digit("old_d1", 4'b0010, 8'h3F);
    run_to(47); chk("fd2", {31'h0, bus.FrameDone}, 32'h1);
    chk("fd2_ready", {31'h0, bus.Ready}, 32'h0);
    run_to(48); chk("swap_ready", {31'h0, bus.Ready}, 32'h1);
    run_to(50); chk_digit("2a_d0", 4'b0001, 8'h77);
    run_to(56); chk_digit("2a_d1", 4'b0010, 8'h5B);
    run_to(62); chk_digit("2a_d2", 4'b0100, 8'h3F);
    run_to(68); chk_digit("2a_d3", 4'b1000, 8'h3F);

    // Leading-zero blanking on 0x002A, and queue 0x0000
    run_to(72); bus.LzBlank = 1'b1; bus.Value = 16'h0000; bus.Load = 1'b1;
    run_to(73); bus.Load = 1'b0;
    run_to(74); chk_digit("lz_d0", 4'b0001, 8'h77);
    run_to(80); chk_digit("lz_d1", 4'b0010, 8'h5B);
    run_to(86); chk_digit("lz_d2", 4'b0100, 8'h00);
    run_to(92); chk_digit("lz_d3", 4'b1000, 8'h00);
    run_to(98);  chk_digit("lz0_d0", 4'b0001, 8'h3F);
    run_to(104); chk_digit("lz0_d1", 4'b0010, 8'h00);
    run_to(116); chk_digit("lz0_d3", 4'b1000, 8'h00);

    // Load on the FrameDone cycle is displayed one frame later
    run_to(119);
    chk("fd_load_fd", {31'h0, bus.FrameDone}, 32'h1);
    chk("fd_load_ready", {31'h0, bus.Ready}, 32'h1);
    bus.LzBlank = 1'b0; bus.Value = 16'h1234; bus.Load = 1'b1;
    run_to(120); bus.Load = 1'b0;
    chk("fd_load_ready_drop", {31'h0, bus.Ready}, 32'h0);
    run_to(122); chk_digit("hold_d0", 4'b0001, 8'h3F);
    run_to(140); chk_digit("hold_d3", 4'b1000, 8'h3F);
    run_to(146); chk_digit("1234_d0", 4'b0001, 8'h66);
    run_to(152); chk_digit("1234_d1", 4'b0010, 8'h4F);
    run_to(158); chk_digit("1234_d2", 4'b0100, 8'h5B);
    run_to(164); chk_digit("1234_d3", 4'b1000, 8'h06);

    // Decimal point mask, including a mid-SHOW change
    run_to(168); bus.DpMask = 4'b0100;
    run_to(170); chk_digit("dp_d0", 4'b0001, 8'h66);
    run_to(176); chk_digit("dp_d1", 4'b0010, 8'h4F);
    run_to(182); chk_digit("dp_d2", 4'b0100, 8'hDB);
    run_to(183); chk_digit("dp_d2b", 4'b0100, 8'hDB);
    bus.DpMask = 4'b0000;
    run_to(184); chk_digit("dp_off", 4'b0100, 8'h5B);

    // Asynchronous reset mid-SHOW of digit 2 with a load pending
    run_to(192); bus.Value = 16'hABCD; bus.Load = 1'b1;
    run_to(193); bus.Load = 1'b0;
    chk("pend_ready", {31'h0, bus.Ready}, 32'h0);
    run_to(206); chk_digit("pre_rst_d2", 4'b0100, 8'h5B);
    #2 Rst_n = 1'b0;
    #1;
    chk_digit("async_rst", 4'b0000, 8'h00);
    chk("async_ready", {31'h0, bus.Ready}, 32'h1);
    chk("async_fd", {31'h0, bus.FrameDone}, 32'h0);
    release_reset();
    chk_digit("rr_c0", 4'b0000, 8'h00);
    run_to(2);  chk_digit("rr_c2", 4'b0001, 8'h3F);
    run_to(23); chk("rr_fd", {31'h0, bus.FrameDone}, 32'h1);
    run_to(24); chk("rr_ready", {31'h0, bus.Ready}, 32'h1);
    run_to(26); chk_digit("rr_d0", 4'b0001, 8'h3F);
    run_to(44); chk_digit("rr_d3", 4'b1000, 8'h3F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
